baby_alu_sequencer: RTL and testbench
=====================================

// Module: baby_alu_sequencer
// PURPOSE
//  Issuing side of the baby ALU opcode/operand interface. Holds a small program of
//  {opcode, operand} entries and, on start, drives one entry per clock into the
//  ALU breadboard's opcode/A inputs. Tracks the ALU carry and captures the final
//  accumulator value. Replaces hand-written testbench stimulus.
// PARAMETERS
//  DEPTH  16  program entries
//  AW     4   program address width (2**AW == DEPTH)
//  DW     2   operand/accumulator width (matches ALU)
//  OPW    4   opcode width (matches ALU)
// PORTS
//  clk        in   1    clock, posedge
//  rst        in   1    synchronous, active-high reset
//  prog_we    in   1    program write strobe
//  prog_addr  in   AW   program write address
//  prog_op    in   OPW  opcode to store
//  prog_arg   in   DW   operand to store
//  start      in   1    start the program from entry 0 (single-cycle pulse)
//  alu_acc    in   DW   ALU accumulator (cur) readback
//  alu_carry  in   1    ALU adder carry-out
//  alu_opcode out  OPW  opcode driven to ALU (registered)
//  alu_a      out  DW   operand driven to ALU A (registered)
//  pc         out  AW   next entry to fetch
//  busy       out  1    high in RUN and DRAIN
//  done       out  1    high in DONE
//  result     out  DW   accumulator captured at end of run
//  carry_seen out  1    sticky: some ADD produced carry during this run
// BEHAVIOUR
//  Opcodes: NOOP=0000 RESET=0001 ADD=0101 AND=1001 issued as is; HALT=1111 is
//   sequencer-only, never issued (NOOP driven instead). Others issued unchanged.
//  Memory: DEPTH x (OPW+DW) regs. Write at posedge if prog_we && !busy; ignored while busy.
//   Contents are not cleared by rst.
//  rst: state=IDLE, pc=0, alu_opcode=NOOP, alu_a=0, done=0, result=0, carry_seen=0.
//  FSM IDLE/DONE --start--> RUN: alu_{opcode,a}<=mem[0], pc<=1, carry_seen<=0, done<=0.
//   Start from DONE restarts identically. start ignored in RUN/DRAIN.
//  RUN each edge: if mem[pc].op==HALT -> outputs<=NOOP/0, ->DRAIN;
//   else outputs<=mem[pc], pc<=pc+1. After entry DEPTH-1 is issued, pc wraps to 0,
//   next edge treats end-of-program as HALT (->DRAIN, outputs NOOP).
//  carry_seen: in RUN, at each edge where alu_opcode==ADD && alu_carry, set to 1.
//  DRAIN (1 cycle, ALU commits last op): next edge result<=alu_acc, ->DONE.
//  DONE: outputs NOOP, done=1 held until start or rst.
//  Latency: HALT at entry N -> done rises at edge N+2 after start edge (N=4 -> 6).
//  rst mid-run wins over all: immediate IDLE, ALU sees NOOP next cycle.
// CONFIGURATION
//  SEQ_AUTOLOOP_EN defined: extra input port `loop` (1b). At end-of-program or HALT
//   with loop=1, RUN instead reloads pc=0 and issues mem[0] same edge; busy stays 1,
//   done never rises; carry_seen keeps accumulating; loop=0 behaves as baseline.
//  Undefined: no `loop` port; every run terminates via DRAIN/DONE.
// TESTING
//  T1 prog {RESET,00}{ADD,01}{ADD,01}{ADD,01}{HALT}; start -> opcodes
//     0001,0101,0101,0101,0000; done 6 edges after start; result=11, carry_seen=0.
//  T2 {RESET,00}{ADD,11}{ADD,01}{HALT} -> result=00, carry_seen=1.
//  T3 {RESET,00}{ADD,11}{AND,10}{HALT} -> result=10, carry_seen=0.
//  T4 16 entries {ADD,01}, no HALT, acc preset 00 -> pc wraps to 0, DRAIN,
//     result=00 (16 mod 4), carry_seen=1, done after 18 edges.
//  T5 rst asserted 2 cycles into T1 -> alu_opcode=0000, busy=0, pc=0; re-start
//     reproduces T1 exactly (memory retained).
//  T6 prog_we/start pulsed while busy -> memory unchanged, run unaffected;
//     SEQ_AUTOLOOP_EN with loop=1 on T1 -> opcode pattern repeats, done stays 0.

Source files
------------

// File: rtl/baby_alu_sequencer.sv
// baby_alu_sequencer: plays a stored {opcode, operand} program into the baby ALU, one entry per clock.
// Build option SEQ_AUTOLOOP_EN adds a `loop` input that restarts the program instead of finishing it.
module baby_alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 2,
  parameter int OPW   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           prog_we,
  input  logic [AW-1:0]  prog_addr,
  input  logic [OPW-1:0] prog_op,
  input  logic [DW-1:0]  prog_arg,
  input  logic           start,
  input  logic [DW-1:0]  alu_acc,
  input  logic           alu_carry,
`ifdef SEQ_AUTOLOOP_EN
  input  logic           loop,
`endif
  output logic [OPW-1:0] alu_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [AW-1:0]  pc,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           carry_seen
);

  // state | meaning
  // IDLE  | waiting for start after reset, ALU held on NOOP
  // RUN   | issuing one program entry per clock
  // DRAIN | ALU commits the last issued op
  // DONE  | result captured, waiting for a restart
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [OPW-1:0] OP_NOOP = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'b1111);

  state_t state;
  state_t state_nxt;

  logic [OPW-1:0] mem_op  [DEPTH];
  logic [DW-1:0]  mem_arg [DEPTH];

  logic [OPW-1:0] fetch_op;
  logic [DW-1:0]  fetch_arg;
  logic [OPW-1:0] head_op;
  logic [DW-1:0]  head_arg;
  logic           head_halt;
  logic           prog_end;
  logic           loop_en;

  logic [OPW-1:0] op_nxt;
  logic [DW-1:0]  a_nxt;
  logic [AW-1:0]  pc_nxt;
  logic [DW-1:0]  result_nxt;
  logic           carry_nxt;

`ifdef SEQ_AUTOLOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign fetch_op  = mem_op[pc];
  assign fetch_arg = mem_arg[pc];
  assign head_op   = mem_op[0];
  assign head_arg  = mem_arg[0];
  assign head_halt = (head_op == OP_HALT);
  // pc only returns to 0 inside RUN by wrapping past the last entry
  assign prog_end  = (pc == '0) || (fetch_op == OP_HALT);

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem_op[prog_addr]  <= prog_op;
      mem_arg[prog_addr] <= prog_arg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = head_halt ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (prog_end && !loop_en) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_nxt     = OP_NOOP;
    a_nxt      = '0;
    pc_nxt     = pc;
    result_nxt = result;
    carry_nxt  = carry_seen;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_nxt    = head_halt ? OP_NOOP : head_op;
          a_nxt     = head_halt ? '0 : head_arg;
          pc_nxt    = head_halt ? '0 : AW'(1);
          carry_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if ((alu_opcode == OP_ADD) && alu_carry) begin
          carry_nxt = 1'b1;
        end
        if (prog_end) begin
          if (loop_en) begin
            op_nxt = head_halt ? OP_NOOP : head_op;
            a_nxt  = head_halt ? '0 : head_arg;
            pc_nxt = head_halt ? '0 : AW'(1);
          end
        end else begin
          op_nxt = fetch_op;
          a_nxt  = fetch_arg;
          pc_nxt = pc + AW'(1);
        end
      end
      S_DRAIN: begin
        result_nxt = alu_acc;
      end
      default: begin
        op_nxt = OP_NOOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= OP_NOOP;
      alu_a      <= '0;
      pc         <= '0;
      result     <= '0;
      carry_seen <= 1'b0;
    end else begin
      alu_opcode <= op_nxt;
      alu_a      <= a_nxt;
      pc         <= pc_nxt;
      result     <= result_nxt;
      carry_seen <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_baby_alu_sequencer.sv
// tb_baby_alu_sequencer: drives the sequencer into a small ALU model and checks it against a program-level model.
// Define SEQ_AUTOLOOP_EN to also exercise the loop input.
module tb_baby_alu_sequencer;

  localparam logic [3:0] NOOP   = 4'b0000;
  localparam logic [3:0] RST_OP = 4'b0001;
  localparam logic [3:0] ADD    = 4'b0101;
  localparam logic [3:0] AND_OP = 4'b1001;
  localparam logic [3:0] HALT   = 4'b1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, prog_we, start;
  logic [3:0] prog_addr, prog_op;
  logic [1:0] prog_arg;
  logic [1:0] alu_acc;
  logic       alu_carry;
  logic [3:0] alu_opcode;
  logic [1:0] alu_a;
  logic [3:0] pc;
  logic       busy, done;
  logic [1:0] result;
  logic       carry_seen;
`ifdef SEQ_AUTOLOOP_EN
  logic       loop;
`endif

  logic [2:0] sum3;
  assign sum3      = {1'b0, alu_acc} + {1'b0, alu_a};
  assign alu_carry = sum3[2];

  baby_alu_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_op(prog_op), .prog_arg(prog_arg), .start(start),
    .alu_acc(alu_acc), .alu_carry(alu_carry),
`ifdef SEQ_AUTOLOOP_EN
    .loop(loop),
`endif
    .alu_opcode(alu_opcode), .alu_a(alu_a), .pc(pc), .busy(busy),
    .done(done), .result(result), .carry_seen(carry_seen)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // program-level model: what a run of the stored program must look like k edges after start
  logic [3:0] m_op  [16];
  logic [1:0] m_arg [16];
  logic [3:0] s_op  [16];
  logic [1:0] s_arg [16];
  logic [1:0] tr_acc [17];
  bit         tr_cov [17];
  bit         active;
  int         h, k;
  logic [1:0] prev_res;
  logic [3:0] exp_op, exp_pc;
  logic [1:0] exp_a, exp_result;
  logic       exp_busy, exp_done, exp_carry;

  task automatic model_start();
    int a;
    bit cov;
    bit found;
    found = 1'b0;
    h = 16;
    for (int i = 0; i < 16; i++) begin
      s_op[i]  = m_op[i];
      s_arg[i] = m_arg[i];
      if (!found && m_op[i] == HALT) begin
        h = i;
        found = 1'b1;
      end
    end
    a = int'(alu_acc);
    cov = 1'b0;
    tr_acc[0] = alu_acc;
    tr_cov[0] = 1'b0;
    for (int i = 0; i < h; i++) begin
      case (s_op[i])
        RST_OP: a = 0;
        ADD: begin
          if (a + int'(s_arg[i]) > 3) cov = 1'b1;
          a = (a + int'(s_arg[i])) % 4;
        end
        AND_OP: a = a & int'(s_arg[i]);
        default: ;
      endcase
      tr_acc[i+1] = 2'(a);
      tr_cov[i+1] = cov;
    end
    prev_res = exp_result;
    k = 0;
    active = 1'b1;
  endtask

  task automatic model_update(input logic r, input logic s, input logic w,
                              input logic [3:0] wa, input logic [3:0] wo, input logic [1:0] wg);
    bit busy_pre;
    if (r) begin
      active = 1'b0;
      exp_op = NOOP; exp_a = 2'd0; exp_pc = 4'd0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_result = 2'd0; exp_carry = 1'b0;
    end else begin
      busy_pre = exp_busy;
      if (s && !busy_pre) model_start();
      else if (active && k <= h + 1) k++;
      if (w && !busy_pre) begin
        m_op[wa]  = wo;
        m_arg[wa] = wg;
      end
      if (active) begin
        exp_op     = (k < h) ? s_op[k] : NOOP;
        exp_a      = (k < h) ? s_arg[k] : 2'd0;
        exp_pc     = 4'((k + 1 < h) ? k + 1 : h);
        exp_busy   = (k <= h);
        exp_done   = (k > h);
        exp_carry  = tr_cov[(k < h) ? k : h];
        exp_result = (k > h) ? tr_acc[h] : prev_res;
      end
    end
  endtask

  // one clock: ALU model commits the op it saw before the edge, then the reference model advances
  task automatic step();
    logic [3:0] ob, wa, wo;
    logic [1:0] ab, wg;
    logic       r, s, w;
    ob = alu_opcode; ab = alu_a;
    r = rst; s = start; w = prog_we; wa = prog_addr; wo = prog_op; wg = prog_arg;
    @(posedge clk);
    #1;
    case (ob)
      RST_OP:  alu_acc = 2'd0;
      ADD:     alu_acc = alu_acc + ab;
      AND_OP:  alu_acc = alu_acc & ab;
      default: ;
    endcase
    model_update(r, s, w, wa, wo, wg);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("opcode",     32'(alu_opcode), 32'(exp_op));
      chk("alu_a",      32'(alu_a),      32'(exp_a));
      chk("pc",         32'(pc),         32'(exp_pc));
      chk("busy",       32'(busy),       32'(exp_busy));
      chk("done",       32'(done),       32'(exp_done));
      chk("result",     32'(result),     32'(exp_result));
      chk("carry_seen", 32'(carry_seen), 32'(exp_carry));
    end
  end

  task automatic wr(input int addr, input logic [3:0] op, input logic [1:0] arg);
    prog_we = 1'b1; prog_addr = 4'(addr); prog_op = op; prog_arg = arg;
    step();
    prog_we = 1'b0;
  endtask

  task automatic load_t1();
    wr(0, RST_OP, 2'b00); wr(1, ADD, 2'b01); wr(2, ADD, 2'b01);
    wr(3, ADD, 2'b01);    wr(4, HALT, 2'b00);
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic lit_run(input string name, input int exp_res, input int exp_cov, input int exp_edges);
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    wait_done(n);
    chk({name, "_edges"},  32'(n),          32'(exp_edges));
    chk({name, "_result"}, 32'(result),     32'(exp_res));
    chk({name, "_carry"},  32'(carry_seen), 32'(exp_cov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] ro;
    rst = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = 4'd0; prog_op = 4'd0; prog_arg = 2'd0; alu_acc = 2'd0;
`ifdef SEQ_AUTOLOOP_EN
    loop = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      m_op[i] = NOOP;
      m_arg[i] = 2'd0;
    end
    exp_busy = 1'b0; exp_result = 2'd0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_opcode", 32'(alu_opcode), 32'd0);
    chk("reset_busy",   32'(busy),       32'd0);
    for (int i = 0; i < 16; i++) wr(i, NOOP, 2'b00);

    load_t1();
    lit_run("t1", 3, 0, 6);

    wr(0, RST_OP, 2'b00); wr(1, ADD, 2'b11); wr(2, ADD, 2'b01); wr(3, HALT, 2'b00);
    lit_run("t2", 0, 1, 5);

    wr(0, RST_OP, 2'b00); wr(1, ADD, 2'b11); wr(2, AND_OP, 2'b10); wr(3, HALT, 2'b00);
    lit_run("t3", 2, 0, 5);

    for (int i = 0; i < 16; i++) wr(i, ADD, 2'b01);
    alu_acc = 2'd0;
    lit_run("t4", 0, 1, 18);

    // T5: reset two cycles into T1, then the retained program replays identically
    load_t1();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_opcode", 32'(alu_opcode), 32'd0);
    chk("t5_busy",   32'(busy),       32'd0);
    chk("t5_pc",     32'(pc),         32'd0);
    lit_run("t5", 3, 0, 6);

    // T6: write and start pulses while busy must not disturb the run or the program
    wr(0, RST_OP, 2'b00); wr(1, ADD, 2'b11); wr(2, ADD, 2'b01); wr(3, HALT, 2'b00);
    start = 1'b1; step(); start = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd1; prog_op = AND_OP; prog_arg = 2'b00; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    n = 2;
    wait_done(n);
    chk("t6_edges",  32'(n),          32'd5);
    chk("t6_result", 32'(result),     32'd0);
    chk("t6_carry",  32'(carry_seen), 32'd1);
    lit_run("t6_rerun", 0, 1, 5);

`ifdef SEQ_AUTOLOOP_EN
    begin
      logic [3:0] pat [4];
      pat[0] = RST_OP; pat[1] = ADD; pat[2] = ADD; pat[3] = ADD;
      load_t1();
      chk_en = 1'b0;
      loop = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      for (int j = 0; j < 12; j++) begin
        if (j > 0) step();
        chk("loop_opcode", 32'(alu_opcode), 32'(pat[j % 4]));
        chk("loop_done",   32'(done),       32'd0);
      end
      loop = 1'b0;
      n = 12;
      wait_done(n);
      rst = 1'b1; step(); rst = 1'b0;
      chk_en = 1'b1;
    end
`endif

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 7))
          0: ro = NOOP;
          1: ro = RST_OP;
          2, 7: ro = ADD;
          3: ro = AND_OP;
          4: ro = ($urandom_range(0, 3) == 0) ? HALT : ADD;
          5: ro = ($urandom_range(0, 5) == 0) ? HALT : RST_OP;
          default: ro = 4'($urandom_range(0, 15));
        endcase
        wr(i, ro, 2'($urandom_range(0, 3)));
      end
      alu_acc = 2'($urandom_range(0, 3));
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
      start = 1'b1; step(); start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
        if ((r % 7) == 3 && n == 3) begin
          rst = 1'b1; step(); rst = 1'b0;
          break;
        end
        prog_we = ($urandom_range(0, 3) == 0);
        prog_addr = 4'($urandom_range(0, 15));
        prog_op = 4'($urandom_range(0, 15));
        prog_arg = 2'($urandom_range(0, 3));
        start = ($urandom_range(0, 5) == 0);
        step();
        prog_we = 1'b0; start = 1'b0;
        n++;
      end
      if (!((r % 7) == 3) && done !== 1'b1) chk("rand_done_timeout", 32'(done), 32'd1);
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
